// File: rtl/nor_logic_unit.sv
// Registered bitwise logic unit realised purely from 2-input NOR primitives, one lane per bit.
// Define NOR_LOGIC_EXT_OPS_EN to add NAND (op 4) and NOR (op 5); otherwise ops 4..7 flag op_err.
module nor_logic_unit #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic             op_err
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  logic [WIDTH-1:0] n1, n2, w1, w2, w3, w4;
  logic [WIDTH-1:0] and_y, or_y, xor_y;
`ifdef NOR_LOGIC_EXT_OPS_EN
  logic [WIDTH-1:0] nand_y;
`endif

  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // n1 doubles as the NOT result and w1 as the NOR result, so those ops need no extra cells
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nor u_n1  (n1[i],    a1[i],    a1[i]);
    nor u_n2  (n2[i],    a2[i],    a2[i]);
    nor u_and (and_y[i], n1[i],    n2[i]);
    nor u_w1  (w1[i],    a1[i],    a2[i]);
    nor u_or  (or_y[i],  w1[i],    w1[i]);
    nor u_w2  (w2[i],    a1[i],    w1[i]);
    nor u_w3  (w3[i],    a2[i],    w1[i]);
    nor u_w4  (w4[i],    w2[i],    w3[i]);
    nor u_xor (xor_y[i], w4[i],    w4[i]);
`ifdef NOR_LOGIC_EXT_OPS_EN
    nor u_nand (nand_y[i], and_y[i], and_y[i]);
`endif
  end

  always_comb begin
    b_d     = b_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (valid_in) begin
      valid_d = 1'b1;
      case (op_e'(op))
        OP_AND:  b_d = and_y;
        OP_OR:   b_d = or_y;
        OP_NOT:  b_d = n1;
        OP_XOR:  b_d = xor_y;
`ifdef NOR_LOGIC_EXT_OPS_EN
        OP_NAND: b_d = nand_y;
        OP_NOR:  b_d = w1;
`endif
        default: begin
          b_d   = '0;
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      b_q     <= b_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign b         = b_q;
  assign valid_out = valid_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_nor_logic_unit.sv
// Scoreboard bench for nor_logic_unit at WIDTH=4: driver queues hand-computed results,
// a negedge monitor pops and compares them, and checks hold behaviour when idle.
module tb_nor_logic_unit;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] a2 = '0;
  logic [W-1:0] b;
  logic         valid_out;
  logic         op_err;

  always #5 clk = ~clk;

  nor_logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .op        (op),
    .a1        (a1),
    .a2        (a2),
    .b         (b),
    .valid_out (valid_out),
    .op_err    (op_err)
  );

  typedef struct {
    logic [W-1:0] b;
    logic         err;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a1;
    logic [W-1:0] a2;
    logic [W-1:0] b;
    logic         err;
  } vec_t;

  exp_t         sb[$];
  exp_t         e;
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [W-1:0] hold_b = '0;
  logic         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("valid_out", 32'(valid_out), 32'd1);
        check("b", 32'(b), 32'(e.b));
        check("op_err", 32'(op_err), 32'(e.err));
        hold_b = e.b;
      end else begin
        check("idle_valid_out", 32'(valid_out), 32'd0);
        check("idle_b_hold", 32'(b), 32'(hold_b));
        check("idle_op_err", 32'(op_err), 32'd0);
      end
    end
  end

  task automatic issue(input vec_t v);
    @(negedge clk);
    #1;
    valid_in = 1'b1;
    op       = v.op;
    a1       = v.a1;
    a2       = v.a2;
    sb.push_back('{b: v.b, err: v.err});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      valid_in = 1'b0;
      op       = 'x;
      a1       = 'x;
      a2       = 'x;
    end
  endtask

  vec_t and_tab[4] = '{
    '{3'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0},
    '{3'd0, 4'b0000, 4'b1111, 4'b0000, 1'b0},
    '{3'd0, 4'b1111, 4'b0000, 4'b0000, 1'b0},
    '{3'd0, 4'b1111, 4'b1111, 4'b1111, 1'b0}
  };

  vec_t main_tab[17] = '{
    '{3'd1, 4'b0000, 4'b0000, 4'b0000, 1'b0},
    '{3'd1, 4'b0000, 4'b1111, 4'b1111, 1'b0},
    '{3'd1, 4'b1111, 4'b0000, 4'b1111, 1'b0},
    '{3'd1, 4'b1111, 4'b1111, 4'b1111, 1'b0},
    '{3'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0},
    '{3'd3, 4'b0000, 4'b1111, 4'b1111, 1'b0},
    '{3'd3, 4'b1111, 4'b0000, 4'b1111, 1'b0},
    '{3'd3, 4'b1111, 4'b1111, 4'b0000, 1'b0},
    '{3'd2, 4'b0000, 4'b0000, 4'b1111, 1'b0},
    '{3'd2, 4'b0000, 4'b1111, 4'b1111, 1'b0},
    '{3'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0},
    '{3'd2, 4'b1111, 4'b1111, 4'b0000, 1'b0},
    '{3'd3, 4'b1100, 4'b1010, 4'b0110, 1'b0},
    '{3'd0, 4'b1100, 4'b1010, 4'b1000, 1'b0},
    '{3'd1, 4'b1100, 4'b1010, 4'b1110, 1'b0},
    '{3'd6, 4'b1111, 4'b1111, 4'b0000, 1'b1},
    '{3'd7, 4'b1100, 4'b1010, 4'b0000, 1'b1}
  };

`ifdef NOR_LOGIC_EXT_OPS_EN
  vec_t ext_tab[4] = '{
    '{3'd4, 4'b1111, 4'b1111, 4'b0000, 1'b0},
    '{3'd4, 4'b1100, 4'b1010, 4'b0111, 1'b0},
    '{3'd5, 4'b0000, 4'b0000, 4'b1111, 1'b0},
    '{3'd5, 4'b1100, 4'b1010, 4'b0001, 1'b0}
  };
`else
  vec_t ext_tab[4] = '{
    '{3'd4, 4'b1111, 4'b1111, 4'b0000, 1'b1},
    '{3'd4, 4'b1100, 4'b1010, 4'b0000, 1'b1},
    '{3'd5, 4'b0000, 4'b0000, 4'b0000, 1'b1},
    '{3'd5, 4'b1100, 4'b1010, 4'b0000, 1'b1}
  };
`endif

  initial begin
    #12;
    check("reset_b", 32'(b), 32'd0);
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_op_err", 32'(op_err), 32'd0);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    foreach (and_tab[i]) issue(and_tab[i]);
    idle(3);
    foreach (main_tab[i]) issue(main_tab[i]);
    foreach (ext_tab[i]) issue(ext_tab[i]);
    idle(1);
    issue('{3'd1, 4'b1111, 4'b0000, 4'b1111, 1'b0});
    idle(2);

    // b is 1111 here; drop reset between clock edges
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrun_reset_b", 32'(b), 32'd0);
    check("midrun_reset_valid_out", 32'(valid_out), 32'd0);
    check("midrun_reset_op_err", 32'(op_err), 32'd0);
    sb.delete();
    hold_b = '0;
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    issue('{3'd3, 4'b1100, 4'b1010, 4'b0110, 1'b0});
    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
